serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Parallel-in, serial-out pattern transmitter. It emits a loaded bit pattern MSB-first on a single serial line, one bit per clock, a programmable number of times with a programmable idle gap between repetitions. It is the driving end of the serial `j` stream consumed by the `moore10010` sequence detector. It replaces hand-timed `j` stimulus with a clock-aligned, repeatable source usable in benches and on-board.

## Interface
Parameters:
- `WIDTH`, 5: pattern length in bits (≥2).
- `REP_W`, 4: width of the repetition count.
- `GAP_W`, 3: width of the inter-repetition gap count.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request to begin a transfer; sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send; `pattern[WIDTH-1]` goes first.
- `reps`  in  REP_W  number of pattern repetitions.
- `gap`  in  GAP_W  idle cycles inserted between repetitions.
- `j`  out  1  serial data, registered.
- `valid`  out  1  `j` carries a pattern bit this cycle.
- `busy`  out  1  transfer in progress (SEND or GAP).
- `done`  out  1  one-cycle pulse after the last bit of the last repetition.

## Operation
- FSM states are IDLE, SEND and GAP. All outputs are registered (Moore).
- Reset (async, any time, including mid-transfer):
  - state goes to IDLE.
  - `j`, `valid`, `busy` and `done` are 0.
  - Shift register, bit counter, repetition counter and gap counter are 0.
  - A transfer interrupted by reset is abandoned and never resumes.
- IDLE:
  - `j`=0, `valid`=0, `busy`=0.
  - On `start`=1 with `reps`≠0: latch `pattern`, `reps` and `gap`, then go to SEND.
  - On `start`=1 with `reps`=0: send nothing, pulse `done` for one cycle, stay in IDLE.
- SEND:
  - Each cycle, drive the current MSB on `j` with `valid`=1 and `busy`=1, and shift left.
  - After WIDTH bits, one repetition is complete.
  - If repetitions remain and the latched `gap`>0, go to GAP.
  - If repetitions remain and the latched `gap`=0, reload the latched pattern and send the next repetition back-to-back, with no bubble.
  - If no repetitions remain, go to IDLE and pulse `done`.
- GAP:
  - `j`=0, `valid`=0, `busy`=1 for exactly the latched `gap` cycles.
  - Then reload the pattern and go to SEND.
- `start` is ignored while `busy`=1. Input changes after latching have no effect.
- The repetition counter counts down from the latched `reps`; there is no wrap-around.

## Timing
- `start` sampled high at rising edge k in IDLE → first bit on `j` from edge k through edge k+1. Latency is 1 cycle.
- One repetition occupies WIDTH cycles.
- Total busy cycles = `reps`·WIDTH + (`reps`−1)·`gap`.
- `done` is high for the single cycle immediately after the last bit. In that cycle `busy`=0 and `j`=0.
- `start` high in the `done` cycle is accepted, because the FSM is in IDLE. The first bit then follows one cycle later and `done` drops.
- `start` coincident with `rst` → reset wins.

## Structure
- Shared package/include `serial_tx_pkg`:
  - State encodings: IDLE=2'b00, SEND=2'b01, GAP=2'b10. The unused code 2'b11 recovers to IDLE.
  - Default values of `WIDTH`, `REP_W` and `GAP_W`.
- One sub-module, `piso_shreg`: WIDTH-bit parallel-load, shift-left register.
  - Inputs: `load`, `shift`, `d`.
  - Output: `msb`.
  - Async active-high reset on `clk`/`rst`.
- Counters and FSM live in the top module.

## Test plan
- Single send: `pattern`=5'b10010, `reps`=1, `gap`=0, `start` pulsed at edge 2.
  - `j`=1,0,0,1,0 with `valid`=1 in cycles 3–7.
  - `done`=1 in cycle 8 only.
  - `busy`=1 in cycles 3–7 only.
- Back-to-back: `pattern`=5'b10010, `reps`=2, `gap`=0.
  - `j`=1001010010 over 10 consecutive cycles, `valid` never drops.
  - `done` one cycle later.
- Gapped: `pattern`=5'b10110, `reps`=3, `gap`=2.
  - Stream is 10110,gap,gap,10110,gap,gap,10110; `valid`=0 and `j`=0 in the gap cycles.
  - 19 busy cycles, then `done`.
- Edge cases:
  - `reps`=0 with `start` → no `valid`, `busy` stays 0, `done` pulses the next cycle.
  - `start` re-pulsed while busy → ignored, stream unchanged.
- Reset mid-transfer: assert `rst` asynchronously between edges during bit 3.
  - All outputs drop to 0 immediately, with no `done`.
  - A new `start` after release sends the full pattern from bit 0.
- Loopback: drive the `j` output into `moore10010` with pattern 10010, `reps`=1.
  - The detector output asserts exactly once, in the cycle after the final 0 is sampled.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and default parameter values.
package serial_tx_pkg;

    // 2'b11 is unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam int unsigned DEF_WIDTH = 5;
    localparam int unsigned DEF_REP_W = 4;
    localparam int unsigned DEF_GAP_W = 3;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-left register; the MSB is the next bit to transmit.
module piso_shreg
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    // Load has priority over shift; zeros fill from the LSB side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, a set number
// of repetitions with an idle gap between them, then pulses done.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned REP_W = DEF_REP_W,
    parameter int unsigned GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             j,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] pat_l;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_l;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] bit_cnt;

    logic             accept;
    logic             last_bit;
    logic             more;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_msb;
    logic [WIDTH-1:0] sh_d;

    // The MSB of each repetition is registered straight onto j, so the shift
    // register is loaded with the remaining bits (pattern << 1).
    always_comb begin
        accept   = (state == IDLE) && start && (reps != '0);
        last_bit = (bit_cnt == LAST_BIT);
        more     = (rep_cnt > REP_W'(1));
        sh_load  = accept
                 || ((state == SEND) && last_bit && more && (gap_l == '0))
                 || ((state == GAP) && (gap_cnt == GAP_W'(1)));
        sh_shift = (state == SEND) && !last_bit;
        sh_d     = accept ? {pattern[WIDTH-2:0], 1'b0} : {pat_l[WIDTH-2:0], 1'b0};
    end

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (sh_d),
        .msb   (sh_msb)
    );

    // FSM with counters and registered outputs; bit_cnt indexes the bit on j.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pat_l   <= '0;
            rep_cnt <= '0;
            gap_l   <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            j       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    j     <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        if (reps != '0) begin
                            pat_l   <= pattern;
                            rep_cnt <= reps;
                            gap_l   <= gap;
                            bit_cnt <= '0;
                            j       <= pattern[WIDTH-1];
                            valid   <= 1'b1;
                            busy    <= 1'b1;
                            state   <= SEND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (!last_bit) begin
                        j       <= sh_msb;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (!more) begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                        bit_cnt <= '0;
                        j       <= 1'b0;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt - 1'b1;
                        bit_cnt <= '0;
                        if (gap_l != '0) begin
                            state   <= GAP;
                            gap_cnt <= gap_l;
                            j       <= 1'b0;
                            valid   <= 1'b0;
                        end else begin
                            j <= pat_l[WIDTH-1];
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state   <= SEND;
                        gap_cnt <= '0;
                        j       <= pat_l[WIDTH-1];
                        valid   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rep_cnt <= '0;
                    gap_cnt <= '0;
                    bit_cnt <= '0;
                    j       <= 1'b0;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: per-cycle comparison against a queue-based
// model of the output stream, directed cases with literal expectations, a
// behavioural 10010 Moore detector on j, and randomized traffic with resets.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] pattern;
    logic [3:0] reps;
    logic [2:0] gap;
    logic       j, valid, busy, done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [3:0] exp_out = 4'b0000;
    logic [3:0] mq[$];
    logic [4:0] hist;
    logic       det;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(5), .REP_W(4), .GAP_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .gap     (gap),
        .j       (j),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    // Model: on an accepted start, expand the whole transfer into a queue of
    // per-cycle {j,valid,busy,done} words; an empty queue means idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_out = 4'b0000;
        end else begin
            if (mq.size() == 0 && start) begin
                for (int r = 0; r < int'(reps); r++) begin
                    for (int b = 4; b >= 0; b--) mq.push_back({pattern[b], 3'b110});
                    if (r < int'(reps) - 1)
                        for (int g = 0; g < int'(gap); g++) mq.push_back(4'b0010);
                end
                mq.push_back(4'b0001);
            end
            exp_out = (mq.size() != 0) ? mq.pop_front() : 4'b0000;
        end
    end

    // Behavioural 10010 Moore detector fed by the serial line.
    always @(posedge clk or posedge rst) begin
        if (rst) hist <= '0;
        else     hist <= {hist[3:0], j};
    end
    assign det = (hist == 5'b10010);

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({j, valid, busy, done} !== exp_out) begin
                errors++;
                $display("FAIL cycle t=%0t {j,valid,busy,done} got=%b exp=%b", $time, {j, valid, busy, done}, exp_out);
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, want);
        end
    endtask

    task automatic send_check(input string name, input logic [4:0] p, input logic [3:0] r,
                              input logic [2:0] g, input bit repulse, input logic [31:0] exp_bits,
                              input int exp_n, input int exp_busy, input int exp_det);
        logic [31:0] bits;
        int n, nb, dcyc, hits;
        bit seen, at_done;
        bits = '0; n = 0; nb = 0; dcyc = -1; hits = 0; seen = 1'b0; at_done = 1'b0;
        @(negedge clk);
        pattern = p; reps = r; gap = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (valid) begin bits = {bits[30:0], j}; n++; end
            if (busy) nb++;
            if (det) begin hits++; if (done) at_done = 1'b1; end
            if (done) begin
                seen = 1'b1;
                dcyc = c;
            end else begin
                if (repulse && c == 1) begin start = 1'b1; pattern = ~p; reps = 4'd3; end
                @(negedge clk);
                start = 1'b0;
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_done_cycle"}, dcyc, exp_busy);
        chk({name, "_nbits"}, n, exp_n);
        chk({name, "_bits"}, bits, exp_bits);
        chk({name, "_busy_cycles"}, nb, exp_busy);
        chk({name, "_det_hits"}, hits, exp_det);
        chk({name, "_det_at_done"}, at_done, (exp_det != 0) ? 1 : 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; reps = '0; gap = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {j, valid, busy, done}, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        send_check("single",  5'b10010, 4'd1, 3'd0, 1'b0, 32'b10010, 5, 5, 1);
        send_check("b2b",     5'b10010, 4'd2, 3'd0, 1'b0, 32'b1001010010, 10, 10, 2);
        send_check("gapped",  5'b10110, 4'd3, 3'd2, 1'b0, 32'b101101011010110, 15, 19, 0);
        send_check("reps0",   5'b10010, 4'd0, 3'd0, 1'b0, 32'b0, 0, 0, 0);
        send_check("repulse", 5'b10010, 4'd1, 3'd0, 1'b1, 32'b10010, 5, 5, 1);

        // Asynchronous reset in the middle of bit 3.
        @(negedge clk);
        pattern = 5'b10010; reps = 4'd1; gap = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_valid", valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {j, valid, busy, done}, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        send_check("after_rst", 5'b10010, 4'd1, 3'd0, 1'b0, 32'b10010, 5, 5, 1);

        // Randomized traffic, with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            pattern = 5'($urandom);
            reps    = 4'($urandom_range(0, 3));
            gap     = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 60) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
